// File: rtl/ac_cool_controller.sv
// AC compressor enable controller for the cooling side of the climate path.
// Adds hysteresis, minimum-run, anti-short-cycle lockout and an occupancy
// hold timer on top of the sensor inputs, interlocked against the heater.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | compressor off, waiting for a start request
// COOL     | compressor on, run_cnt counts towards the minimum run time
// LOCKOUT  | compressor off, start ignored for MIN_OFF cycles (also after reset)
module ac_cool_controller #(
  parameter int TEMP_W        = 8,
  parameter int HIGH_THRESH   = 26,
  parameter int HYST          = 2,
  parameter int MIN_ON        = 4,
  parameter int MIN_OFF       = 3,
  parameter int PRESENCE_HOLD = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp,
  input  logic              presence,
  input  logic              window,
  input  logic              heating_system,
  output logic              ac_cool,
  output logic              lockout,
  output logic              occupied
);

  if (HYST > HIGH_THRESH) begin : g_hyst_chk
    $error("ac_cool_controller: HYST must not exceed HIGH_THRESH");
  end
  if (MIN_ON < 1 || MIN_OFF < 1 || PRESENCE_HOLD < 0) begin : g_dur_chk
    $error("ac_cool_controller: MIN_ON/MIN_OFF must be >= 1, PRESENCE_HOLD >= 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOL    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam int RUN_W  = (MIN_ON > 1)        ? $clog2(MIN_ON)            : 1;
  localparam int LOCK_W = (MIN_OFF > 1)       ? $clog2(MIN_OFF)           : 1;
  localparam int OCC_W  = (PRESENCE_HOLD > 0) ? $clog2(PRESENCE_HOLD + 1) : 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MIN_ON - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MIN_OFF - 1);
  localparam logic [OCC_W-1:0]  OCC_LOAD  = OCC_W'(PRESENCE_HOLD);
  localparam logic [TEMP_W-1:0] START_T   = TEMP_W'(HIGH_THRESH);
  localparam logic [TEMP_W-1:0] STOP_T    = TEMP_W'(HIGH_THRESH - HYST);

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [OCC_W-1:0]    occ_cnt_q, occ_cnt_d;
  logic                ac_cool_q, ac_cool_d;
  logic                lockout_q, lockout_d;

  logic start;
  logic force_stop;
  logic normal_stop;

  // Occupancy: presence reloads the hold timer, otherwise it drains to zero.
  always_comb begin
    occ_cnt_d = occ_cnt_q;
    if (presence) begin
      occ_cnt_d = OCC_LOAD;
    end else if (occ_cnt_q != '0) begin
      occ_cnt_d = occ_cnt_q - OCC_W'(1);
    end
  end

  assign occupied = presence | (occ_cnt_q != '0);

  // Heater interlock is absolute: it both blocks a start and forces a stop.
  assign start       = occupied & ~window & ~heating_system & (temp > START_T);
  assign force_stop  = window | heating_system;
  assign normal_stop = ~occupied | (temp <= STOP_T);

  // Next-state and counter logic; force_stop has priority over normal_stop.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_COOL;
          run_cnt_d = '0;
        end
      end
      ST_COOL: begin
        if (force_stop) begin
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
        end else if (normal_stop && (run_cnt_q == RUN_LAST)) begin
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
        end else if (run_cnt_q != RUN_LAST) begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: begin
        state_d    = ST_LOCKOUT;
        lock_cnt_d = '0;
      end
    endcase
    ac_cool_d = (state_d == ST_COOL);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  // State, counters and registered outputs; reset parks the compressor in lockout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOCKOUT;
      run_cnt_q  <= '0;
      lock_cnt_q <= '0;
      occ_cnt_q  <= '0;
      ac_cool_q  <= 1'b0;
      lockout_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      occ_cnt_q  <= occ_cnt_d;
      ac_cool_q  <= ac_cool_d;
      lockout_q  <= lockout_d;
    end
  end

  assign ac_cool = ac_cool_q;
  assign lockout = lockout_q;

endmodule

// File: tb/tb_ac_cool_controller.sv
// Scoreboard bench for ac_cool_controller: the driver advances a behavioural
// model each cycle and queues the expected outputs; the monitor pops and
// compares after every clock edge and every reset assertion.
module tb_ac_cool_controller;

  localparam int TEMP_W        = 8;
  localparam int HIGH_THRESH   = 26;
  localparam int HYST          = 2;
  localparam int MIN_ON        = 4;
  localparam int MIN_OFF       = 3;
  localparam int PRESENCE_HOLD = 5;

  localparam int M_IDLE = 0;
  localparam int M_COOL = 1;
  localparam int M_LOCK = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [TEMP_W-1:0] temp;
  logic              presence;
  logic              window;
  logic              heating_system;
  logic              ac_cool;
  logic              lockout;
  logic              occupied;

  ac_cool_controller #(
    .TEMP_W        (TEMP_W),
    .HIGH_THRESH   (HIGH_THRESH),
    .HYST          (HYST),
    .MIN_ON        (MIN_ON),
    .MIN_OFF       (MIN_OFF),
    .PRESENCE_HOLD (PRESENCE_HOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .temp           (temp),
    .presence       (presence),
    .window         (window),
    .heating_system (heating_system),
    .ac_cool        (ac_cool),
    .lockout        (lockout),
    .occupied       (occupied)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ac;
    logic lk;
    logic occ;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: mode, cycles spent cooling, lockout cycles still to
  // serve, and occupancy hold cycles still to run.
  int m_mode;
  int m_ran;
  int m_lock_left;
  int m_hold;

  function automatic void model_reset();
    m_mode      = M_LOCK;
    m_ran       = 0;
    m_lock_left = MIN_OFF;
    m_hold      = 0;
  endfunction

  function automatic void model_step();
    bit occ_now, start, fstop, nstop;
    occ_now = presence || (m_hold > 0);
    start   = occ_now && !window && !heating_system && (int'(temp) > HIGH_THRESH);
    fstop   = window || heating_system;
    nstop   = !occ_now || (int'(temp) <= HIGH_THRESH - HYST);
    if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode = M_COOL;
        m_ran  = 1;
      end
    end else if (m_mode == M_COOL) begin
      if (fstop || (nstop && m_ran >= MIN_ON)) begin
        m_mode      = M_LOCK;
        m_lock_left = MIN_OFF;
      end else begin
        m_ran++;
      end
    end else begin
      m_lock_left--;
      if (m_lock_left == 0) m_mode = M_IDLE;
    end
    if (presence) m_hold = PRESENCE_HOLD;
    else if (m_hold > 0) m_hold--;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.ac  = (m_mode == M_COOL);
    e.lk  = (m_mode == M_LOCK);
    e.occ = presence || (m_hold > 0);
    sb_q.push_back(e);
  endfunction

  function automatic void check(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
  endfunction

  // Monitor: one expectation per clock edge or reset assertion.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty at %0t: actual=no expectation required=one queued", $time);
      end else begin
        e = sb_q.pop_front();
        check("ac_cool", ac_cool, e.ac);
        check("lockout", lockout, e.lk);
        check("occupied", occupied, e.occ);
      end
    end
  end

  task automatic set_in(input int t, input bit p, input bit w, input bit h);
    temp           = TEMP_W'(t);
    presence       = p;
    window         = w;
    heating_system = h;
  endtask

  task automatic drive_cycle(input int t, input bit p, input bit w, input bit h);
    @(negedge clk);
    set_in(t, p, w, h);
    model_step();
    push_exp();
  endtask

  task automatic drive_n(input int n, input int t, input bit p, input bit w, input bit h);
    for (int i = 0; i < n; i++) drive_cycle(t, p, w, h);
  endtask

  // Reset asserted between edges (checked on the rising reset itself), held
  // across one clock edge, released on the following falling edge.
  task automatic pulse_reset(input int t, input bit p, input bit w, input bit h);
    @(negedge clk);
    set_in(t, p, w, h);
    model_reset();
    push_exp();
    #2 rst = 1'b1;
    push_exp();
    @(negedge clk);
    rst = 1'b0;
    model_step();
    push_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    bit p, w, h;
    rst = 1'b1;
    set_in(30, 1'b1, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;
    push_exp();
    @(negedge clk);
    rst = 1'b0;
    model_step();
    push_exp();

    // Lockout after reset, one idle cycle, then cooling starts.
    drive_n(6, 30, 1'b1, 1'b0, 1'b0);
    // Temperature drops early in the run: minimum run, then lockout.
    drive_n(10, 23, 1'b1, 1'b0, 1'b0);
    // Restart, then open the window mid-run; no restart while open.
    drive_n(6, 30, 1'b1, 1'b0, 1'b0);
    drive_n(8, 30, 1'b1, 1'b1, 1'b0);
    // Presence pulse: occupancy hold ends the run once expired.
    drive_n(5, 30, 1'b1, 1'b0, 1'b0);
    drive_cycle(30, 1'b1, 1'b0, 1'b0);
    drive_n(14, 30, 1'b0, 1'b0, 1'b0);
    // Hysteresis band: 27 starts, 25 holds, 24 stops; 26 never starts.
    drive_n(4, 27, 1'b1, 1'b0, 1'b0);
    drive_n(4, 25, 1'b1, 1'b0, 1'b0);
    drive_n(6, 24, 1'b1, 1'b0, 1'b0);
    drive_n(8, 26, 1'b1, 1'b0, 1'b0);
    // Heater active blocks starting; then reset in the middle of a run.
    drive_n(6, 30, 1'b1, 1'b0, 1'b1);
    drive_n(3, 30, 1'b1, 1'b0, 1'b0);
    pulse_reset(30, 1'b1, 1'b0, 1'b0);
    drive_n(6, 30, 1'b1, 1'b0, 1'b0);

    // Randomized traffic around the thresholds.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset(30, 1'b1, 1'b0, 1'b0);
      end else begin
        t = int'($urandom_range(20, 32));
        p = ($urandom_range(0, 9) < 6);
        w = ($urandom_range(0, 15) == 0);
        h = ($urandom_range(0, 15) == 0);
        drive_cycle(t, p, w, h);
      end
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: actual=%0d left required=0 left", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
